// File: rtl/mult_op_scheduler.sv
// mult_op_scheduler: operand FIFO plus launch/capture sequencer that feeds a
// sum-and-shift multiplier one operation at a time and returns its product
// on a valid/ready port. A WAIT timeout flags a multiplier that never answers.
module mult_op_scheduler #(
   parameter int size    = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 40
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [size-1:0]   IN_A,
   input  logic [size-1:0]   IN_B,
   output logic              START,
   output logic [size-1:0]   A,
   output logic [size-1:0]   B,
   input  logic [2*size-1:0] S,
   input  logic              END_MULT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [2*size-1:0] OUT_S,
   output logic              BUSY,
   output logic              ERR
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [2*size-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [CW-1:0]     r_wait_cnt;
   logic              r_end_prev;
   logic              r_start;
   logic [size-1:0]   r_a;
   logic [size-1:0]   r_b;
   logic              r_out_valid;
   logic [2*size-1:0] r_out_s;
   logic              r_err;

   logic              w_push;
   logic              w_launch;
   logic              w_fifo_empty;
   logic              w_end_rise;
   logic              w_capture;
   logic              w_timeout;
   logic [2*size-1:0] w_head;

   // IN_READY and BUSY come only from registered state, never from inputs.
   assign w_fifo_empty = (r_count == '0);
   assign IN_READY     = (r_count != (AW+1)'(DEPTH));
   assign BUSY         = (r_state != ST_IDLE) | ~w_fifo_empty | r_out_valid;

   assign w_push     = IN_VALID & IN_READY;
   assign w_launch   = (r_state == ST_IDLE) & ~w_fifo_empty & ~r_out_valid;
   assign w_head     = r_mem[r_rd_ptr];
   // Only a fresh rise counts; a level left high from a previous op is ignored.
   assign w_end_rise = END_MULT & ~r_end_prev;
   assign w_capture  = (r_state == ST_WAIT) & w_end_rise;
   assign w_timeout  = (r_state == ST_WAIT) & ~w_end_rise &
                       (r_wait_cnt == CW'(TIMEOUT - 1));

   assign START     = r_start;
   assign A         = r_a;
   assign B         = r_b;
   assign OUT_VALID = r_out_valid;
   assign OUT_S     = r_out_s;
   assign ERR       = r_err;

   // Operand storage: no reset needed, occupancy is tracked by r_count.
   always_ff @(posedge CLOCK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {IN_A, IN_B};
      end
   end

   // FIFO pointers and occupancy; pop happens only on the launch transition.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_launch) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_launch})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode: IDLE -> LAUNCH -> WAIT -> IDLE (capture or timeout).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_launch) w_state_next = ST_LAUNCH;
         ST_LAUNCH: w_state_next = ST_WAIT;
         ST_WAIT:   if (w_capture || w_timeout) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Launch pulse and operand hold: A/B stay put until the next launch.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_start <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_start <= w_launch;
         if (w_launch) begin
            r_a <= w_head[2*size-1:size];
            r_b <= w_head[size-1:0];
         end
      end
   end

   // WAIT cycle counter, cleared while in LAUNCH.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_LAUNCH) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
         r_wait_cnt <= r_wait_cnt + CW'(1);
      end
   end

   // Previous END_MULT level for rise detection.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_end_prev <= 1'b0;
      end else begin
         r_end_prev <= END_MULT;
      end
   end

   // Result register and sticky timeout flag.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_out_valid <= 1'b0;
         r_out_s     <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_out_valid && OUT_READY) begin
            r_out_valid <= 1'b0;
         end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_s     <= S;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule
